// File: rtl/fp_div_seq_if.sv
// Handshake/data bundle between a requester and fp_div_seq.
// Latency/backpressure are owned by the divider: in_start is sampled only while out_stall=0.
// Ports: in_start, in_numA, in_numB (requester -> divider); out_stall, out_valid, out_result, out_flags (divider -> requester).
interface fp_div_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_start;
  logic [W-1:0] in_numA;
  logic [W-1:0] in_numB;
  logic         out_stall;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic [4:0]   out_flags;

  modport master (
    output in_start, in_numA, in_numB,
    input  out_stall, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_start, in_numA, in_numB,
    output out_stall, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: restoring bit-serial mantissa divide, RNE rounding, exception flags.
// Latency MAN_W+5 edges for normal operands, 1 edge for special operands; one result per MAN_W+6 / 1 cycles.
// Backpressure: out_stall high while busy, in_start ignored then (no queueing); out_valid is a one-cycle pulse.
// Ports: in_Clk, in_Rst_N (async active-low), bus (slave side of fp_div_seq_if).
//   out_flags = {invalid, divzero, overflow, underflow, inexact}; out_result/out_flags held until next out_valid.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          in_Clk,
  input  logic          in_Rst_N,
  fp_div_seq_if.slave   bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;           // mantissa with hidden bit
  localparam int RW = M + 1;               // remainder (dividend may be pre-shifted by one)
  localparam int QW = MAN_W + 3;           // integer bit + fraction + guard + round
  localparam int EW = EXP_W + 2;           // signed working exponent
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

  state_t                state, state_nx;
  logic                  stall_q;
  logic                  sign_q;
  logic [EXP_W-1:0]      ea_q, eb_q;
  logic [MAN_W-1:0]      fa_q, fb_q;
  logic signed [EW-1:0]  exp_q;
  logic [RW-1:0]         rem_q;
  logic [M-1:0]          div_q;
  logic [QW-1:0]         quo_q;
  logic [CW-1:0]         cnt_q;
  logic [W-1:0]          result_q;
  logic [4:0]            flags_q;

  // ---------------- operand classification (on the live inputs) ----------------
  logic                  a_sign, b_sign, sign_in;
  logic [EXP_W-1:0]      a_exp, b_exp;
  logic [MAN_W-1:0]      a_frac, b_frac;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sign  = bus.in_numA[W-1];
  assign b_sign  = bus.in_numB[W-1];
  assign a_exp   = bus.in_numA[W-2:MAN_W];
  assign b_exp   = bus.in_numB[W-2:MAN_W];
  assign a_frac  = bus.in_numA[MAN_W-1:0];
  assign b_frac  = bus.in_numB[MAN_W-1:0];
  assign sign_in = a_sign ^ b_sign;

  // exp==0 covers both true zero and subnormals (flushed to zero)
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_frac == '0);
  assign b_inf  = (b_exp == '1) && (b_frac == '0);
  assign a_nan  = (a_exp == '1) && (a_frac != '0);
  assign b_nan  = (b_exp == '1) && (b_frac != '0);

  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags = 5'b10000;
    end else if (b_zero && !a_zero && !a_inf) begin
      spec_res   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 5'b01000;
    end else if (a_inf) begin
      spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------- FSM next state ----------------
  logic load_op;

  always_comb begin
    state_nx = state;
    load_op  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (bus.in_start) begin
          load_op  = 1'b1;
          state_nx = spec_hit ? DONE : PREP;
        end
      end
      PREP:    state_nx = DIV;
      DIV:     if (cnt_q == CNT_LAST) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- PREP: exponent difference and mantissa alignment ----------------
  logic [M-1:0]         ma, mb;
  logic signed [EW-1:0] e_prep;
  logic [RW-1:0]        rem_init;

  always_comb begin
    ma       = {1'b1, fa_q};
    mb       = {1'b1, fb_q};
    e_prep   = signed'({2'b00, ea_q}) - signed'({2'b00, eb_q}) + BIAS;
    rem_init = {1'b0, ma};
    // Pre-shift so the quotient always lands in [1,2): integer bit is 1
    if (ma < mb) begin
      rem_init = {ma, 1'b0};
      e_prep   = e_prep - EW'(1);
    end
  end

  // ---------------- DIV: one restoring step ----------------
  logic          q_bit;
  logic [RW-1:0] rem_diff, rem_step;

  always_comb begin
    q_bit    = (rem_q >= {1'b0, div_q});
    rem_diff = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
    // rem_diff < divisor < 2^M, so dropping the top bit on shift is lossless
    rem_step = {rem_diff[RW-2:0], 1'b0};
  end

  // ---------------- ROUND: RNE, range check, pack ----------------
  logic                 guard, rnd, sticky, lsb, inc, inexact, carry;
  logic [M:0]           mant_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flags;

  always_comb begin
    guard   = quo_q[1];
    rnd     = quo_q[0];
    lsb     = quo_q[2];
    sticky  = (rem_q != '0);
    inc     = guard & (rnd | sticky | lsb);
    inexact = guard | rnd | sticky;
    mant_r  = {1'b0, quo_q[QW-1:2]} + {{M{1'b0}}, inc};
    carry   = mant_r[M];
    // On carry-out the low M bits are already all zero, so the fraction needs no fix-up
    e_r     = carry ? (exp_q + EW'(1)) : exp_q;
    if (e_r >= EMAX) begin
      rnd_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 5'b00101;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      rnd_res   = {sign_q, {(W-1){1'b0}}};
      rnd_flags = 5'b00011;
    end else begin
      rnd_res   = {sign_q, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
      rnd_flags = {4'b0000, inexact};
    end
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state    <= IDLE;
      stall_q  <= 1'b0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state   <= state_nx;
      stall_q <= (state_nx == PREP) || (state_nx == DIV) || (state_nx == ROUND);
      if (load_op) begin
        sign_q <= sign_in;
        ea_q   <= a_exp;
        eb_q   <= b_exp;
        fa_q   <= a_frac;
        fb_q   <= b_frac;
      end
      case (state)
        PREP: begin
          exp_q <= e_prep;
          rem_q <= rem_init;
          div_q <= mb;
          quo_q <= '0;
          cnt_q <= '0;
        end
        DIV: begin
          rem_q <= rem_step;
          quo_q <= {quo_q[QW-2:0], q_bit};
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
      // Outputs only move on the edge that enters DONE; load_op there means a special result
      if (state_nx == DONE) begin
        result_q <= load_op ? spec_res   : rnd_res;
        flags_q  <= load_op ? spec_flags : rnd_flags;
      end
    end
  end

  assign bus.out_stall  = stall_q;
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: binary32 instance plus a binary16 instance.
// Expected values are hand-computed IEEE results; outputs sampled 1 time unit after the rising edge.
// Ports: drives both DUT instances through fp_div_seq_if interfaces, shared clock and reset.
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  fp_div_seq_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  fp_div_seq_if #(.EXP_W(5), .MAN_W(10)) b16 ();

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.in_Clk(clk), .in_Rst_N(rst_n), .bus(b32));
  fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.in_Clk(clk), .in_Rst_N(rst_n), .bus(b16));

  // Start one binary32 operation; lat = edge index (0 = accepting edge) at which out_valid is seen, -1 on timeout.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [4:0] fl,
                       output int lat, output int nostall);
    @(negedge clk);
    b32.in_numA = a; b32.in_numB = b; b32.in_start = 1'b1;
    @(posedge clk); #1;
    b32.in_start = 1'b0; b32.in_numA = '0; b32.in_numB = '0;
    lat = 0; nostall = 0;
    while (!b32.out_valid && lat < 200) begin
      if (!b32.out_stall) nostall++;
      @(posedge clk); #1;
      lat++;
    end
    if (!b32.out_valid) lat = -1;
    res = b32.out_result; fl = b32.out_flags;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [4:0] fl, output int lat);
    @(negedge clk);
    b16.in_numA = a; b16.in_numB = b; b16.in_start = 1'b1;
    @(posedge clk); #1;
    b16.in_start = 1'b0; b16.in_numA = '0; b16.in_numB = '0;
    lat = 0;
    while (!b16.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!b16.out_valid) lat = -1;
    res = b16.out_result; fl = b16.out_flags;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_tests++; if (b32.out_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", b32.out_stall); end
    n_tests++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b32.out_valid); end
    n_tests++; if (b32.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", b32.out_result); end
    n_tests++; if (b32.out_flags !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0", b32.out_flags); end
  endtask

  task automatic test_normal();
    logic [31:0] r; logic [4:0] f; int lat, ns;
    run32(32'h40C00000, 32'h40000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL div6_2_result got %h want 40400000", r); end
    n_tests++; if (f !== 5'b00000) begin n_fail++; $display("FAIL div6_2_flags got %b want 00000", f); end
    n_tests++; if (lat !== 28) begin n_fail++; $display("FAIL div6_2_latency got %0d want 28", lat); end
    n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL div6_2_stall_gaps got %0d want 0", ns); end
    n_tests++; if (b32.out_stall !== 1'b0) begin n_fail++; $display("FAIL div6_2_stall_done got %b want 0", b32.out_stall); end
    // result must be held after the valid pulse
    repeat (3) @(posedge clk); #1;
    n_tests++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b want 0", b32.out_valid); end
    n_tests++; if (b32.out_result !== 32'h40400000) begin n_fail++; $display("FAIL hold_result got %h want 40400000", b32.out_result); end
    run32(32'h3F800000, 32'h40400000, r, f, lat, ns);
    n_tests++; if (r !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL div1_3_result got %h want 3eaaaaab", r); end
    n_tests++; if (f !== 5'b00001) begin n_fail++; $display("FAIL div1_3_flags got %b want 00001", f); end
  endtask

  task automatic test_half();
    logic [15:0] r; logic [4:0] f; int lat;
    run16(16'h3C00, 16'h4200, r, f, lat);
    n_tests++; if (r !== 16'h3555) begin n_fail++; $display("FAIL h_div1_3_result got %h want 3555", r); end
    n_tests++; if (f !== 5'b00001) begin n_fail++; $display("FAIL h_div1_3_flags got %b want 00001", f); end
    n_tests++; if (lat !== 15) begin n_fail++; $display("FAIL h_div1_3_latency got %0d want 15", lat); end
    run16(16'h4600, 16'h4000, r, f, lat);
    n_tests++; if (r !== 16'h4200) begin n_fail++; $display("FAIL h_div6_2_result got %h want 4200", r); end
    n_tests++; if (f !== 5'b00000) begin n_fail++; $display("FAIL h_div6_2_flags got %b want 00000", f); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] f; int lat, ns;
    run32(32'h3F800000, 32'h00000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL divzero_result got %h want 7f800000", r); end
    n_tests++; if (f !== 5'b01000) begin n_fail++; $display("FAIL divzero_flags got %b want 01000", f); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL divzero_latency got edge %0d want edge 0", lat); end
    n_tests++; if (b32.out_stall !== 1'b0) begin n_fail++; $display("FAIL divzero_stall got %b want 0", b32.out_stall); end
    run32(32'h00000000, 32'h00000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL zero_zero_result got %h want 7fc00000", r); end
    n_tests++; if (f !== 5'b10000) begin n_fail++; $display("FAIL zero_zero_flags got %b want 10000", f); end
    run32(32'h7F800000, 32'hFF800000, r, f, lat, ns);
    n_tests++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL inf_inf_result got %h want 7fc00000", r); end
    n_tests++; if (f !== 5'b10000) begin n_fail++; $display("FAIL inf_inf_flags got %b want 10000", f); end
    run32(32'h7FC00001, 32'h00000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL nan_result got %h want 7fc00000", r); end
    n_tests++; if (f !== 5'b00000) begin n_fail++; $display("FAIL nan_flags got %b want 00000", f); end
    run32(32'hFF800000, 32'h40000000, r, f, lat, ns);
    n_tests++; if (r !== 32'hFF800000) begin n_fail++; $display("FAIL ninf_result got %h want ff800000", r); end
    n_tests++; if (f !== 5'b00000) begin n_fail++; $display("FAIL ninf_flags got %b want 00000", f); end
    run32(32'h80000000, 32'h3F800000, r, f, lat, ns);
    n_tests++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL nzero_result got %h want 80000000", r); end
    run32(32'h3F800000, 32'hFF800000, r, f, lat, ns);
    n_tests++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL fin_inf_result got %h want 80000000", r); end
  endtask

  task automatic test_range();
    logic [31:0] r; logic [4:0] f; int lat, ns;
    run32(32'h7F7FFFFF, 32'h3F000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_result got %h want 7f800000", r); end
    n_tests++; if (f !== 5'b00101) begin n_fail++; $display("FAIL ovf_flags got %b want 00101", f); end
    n_tests++; if (lat !== 28) begin n_fail++; $display("FAIL ovf_latency got %0d want 28", lat); end
    run32(32'h00800000, 32'h40000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL unf_result got %h want 00000000", r); end
    n_tests++; if (f !== 5'b00011) begin n_fail++; $display("FAIL unf_flags got %b want 00011", f); end
    run32(32'h00000001, 32'h3F800000, r, f, lat, ns);
    n_tests++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL subn_result got %h want 00000000", r); end
    n_tests++; if (f !== 5'b00000) begin n_fail++; $display("FAIL subn_flags got %b want 00000", f); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL subn_latency got edge %0d want edge 0", lat); end
  endtask

  task automatic test_ignore_start();
    int nv, first;
    logic [31:0] r;
    nv = 0; first = -1; r = '0;
    @(negedge clk);
    b32.in_numA = 32'h40C00000; b32.in_numB = 32'h40000000; b32.in_start = 1'b1;
    @(posedge clk); #1;
    b32.in_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      b32.in_numA = 32'h3F800000; b32.in_numB = 32'h40400000;
      b32.in_start = (k == 5 || k == 10 || k == 20);
      @(posedge clk); #1;
      b32.in_start = 1'b0;
      if (b32.out_valid) begin
        nv++;
        if (first < 0) begin first = k; r = b32.out_result; end
      end
    end
    n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL ignore_count got %0d want 1", nv); end
    n_tests++; if (first !== 28) begin n_fail++; $display("FAIL ignore_latency got %0d want 28", first); end
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL ignore_result got %h want 40400000", r); end
  endtask

  task automatic test_back_to_back();
    int nv, e1, e2;
    logic [31:0] r1, r2;
    nv = 0; e1 = -1; e2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    b32.in_numA = 32'h40C00000; b32.in_numB = 32'h40000000; b32.in_start = 1'b1;
    @(posedge clk); #1;
    b32.in_numA = 32'h3F800000; b32.in_numB = 32'h40400000;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 29) b32.in_start = 1'b0;
      if (b32.out_valid) begin
        nv++;
        if (nv == 1) begin e1 = k; r1 = b32.out_result; end
        else begin e2 = k; r2 = b32.out_result; end
      end
    end
    b32.in_start = 1'b0;
    n_tests++; if (nv !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", nv); end
    n_tests++; if (r1 !== 32'h40400000) begin n_fail++; $display("FAIL b2b_first got %h want 40400000", r1); end
    n_tests++; if (r2 !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL b2b_second got %h want 3eaaaaab", r2); end
    n_tests++; if (e1 !== 28) begin n_fail++; $display("FAIL b2b_first_edge got %0d want 28", e1); end
    n_tests++; if (e2 - e1 !== 29) begin n_fail++; $display("FAIL b2b_spacing got %0d want 29", e2 - e1); end
    // two special operations back to back: valid stays high, result changes each cycle
    @(negedge clk);
    b32.in_numA = 32'h3F800000; b32.in_numB = 32'h00000000; b32.in_start = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (b32.out_valid !== 1'b1 || b32.out_result !== 32'h7F800000)
      begin n_fail++; $display("FAIL sp_b2b_first got v=%b %h want v=1 7f800000", b32.out_valid, b32.out_result); end
    b32.in_numA = 32'h00000000;
    @(posedge clk); #1;
    n_tests++; if (b32.out_valid !== 1'b1 || b32.out_result !== 32'h7FC00000 || b32.out_flags !== 5'b10000)
      begin n_fail++; $display("FAIL sp_b2b_second got v=%b %h %b want v=1 7fc00000 10000", b32.out_valid, b32.out_result, b32.out_flags); end
    b32.in_start = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL sp_b2b_end got %b want 0", b32.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] f; int lat, ns, nv;
    nv = 0;
    @(negedge clk);
    b32.in_numA = 32'h40C00000; b32.in_numB = 32'h40000000; b32.in_start = 1'b1;
    @(posedge clk); #1;
    b32.in_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (b32.out_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b want 0", b32.out_stall); end
    n_tests++; if (b32.out_result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got %h want 0", b32.out_result); end
    n_tests++; if (b32.out_flags !== 5'b0) begin n_fail++; $display("FAIL midrst_flags got %b want 0", b32.out_flags); end
    repeat (3) begin
      @(posedge clk); #1;
      if (b32.out_valid) nv++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (b32.out_valid) nv++;
    end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL midrst_valid got %0d pulses want 0", nv); end
    run32(32'h40C00000, 32'h40000000, r, f, lat, ns);
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL post_rst_result got %h want 40400000", r); end
    n_tests++; if (lat !== 28) begin n_fail++; $display("FAIL post_rst_latency got %0d want 28", lat); end
  endtask

  initial begin
    b32.in_start = 1'b0; b32.in_numA = '0; b32.in_numB = '0;
    b16.in_start = 1'b0; b16.in_numA = '0; b16.in_numB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_normal();
    test_half();
    test_special();
    test_range();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
